// File: rtl/btn_cmd_arbiter.sv
// Four-button debouncer with edge events, pending flags and a round-robin command presenter.
// Optional build macro BTN_AUTO_REPEAT_EN adds per-button auto-repeat events while a button is held.
module btn_cmd_arbiter #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DB_CNT    = 4,
  parameter int unsigned RPT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_u,
  input  logic       btn_lw,
  input  logic       btn_lft,
  input  logic       btn_ri,
  input  logic       cmd_ready,
  input  logic       ovf_clr,
  output logic       cmd_valid,
  output logic [1:0] cmd_id,
  output logic [3:0] pend,
  output logic       ovf
);

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 4;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  logic [NB-1:0]    raw_c;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    stable_d;
  logic [CW-1:0]    db_cnt [NB];
  logic [NB-1:0]    rise_c;
  logic [NB-1:0]    evt_c;
  logic [NB-1:0]    clr_c;
  logic             ovf_set_c;

  state_t           state;
  state_t           state_n;
  logic [1:0]       cmd_id_n;
  logic             cmd_valid_n;
  logic [1:0]       last;
  logic [1:0]       last_n;
  logic [1:0]       sel_c;
  logic [1:0]       idx_c;

  assign raw_c = {btn_ri, btn_lft, btn_lw, btn_u};

  // two-flop synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
    end
  end

  // free-running sample divider; tick marks the cycle whose edge wraps it to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick_c = &div_cnt;

  // debounce: a changed level must persist for DB_CNT consecutive ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else if (tick_c) begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == CW'(DB_CNT - 1)) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_d <= '0;
    else        stable_d <= stable;
  end

  assign rise_c = stable & ~stable_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RW = (RPT_TICKS > 1) ? $clog2(RPT_TICKS) : 1;

  logic [RW-1:0] rpt_cnt [NB];
  logic [NB-1:0] rpt_evt;

  // held buttons re-fire every RPT_TICKS ticks after the press event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_evt <= '0;
      for (int i = 0; i < NB; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        rpt_evt[i] <= 1'b0;
        if (!stable[i]) begin
          rpt_cnt[i] <= '0;
        end else if (tick_c) begin
          if (rpt_cnt[i] == RW'(RPT_TICKS - 1)) begin
            rpt_cnt[i] <= '0;
            rpt_evt[i] <= 1'b1;
          end else begin
            rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
          end
        end
      end
    end
  end

  assign evt_c = rise_c | rpt_evt;
`else
  assign evt_c = rise_c;
`endif

  assign clr_c     = (state == PRESENT && cmd_ready) ? (NB'(1) << cmd_id) : '0;
  assign ovf_set_c = |(evt_c & pend & ~clr_c);

  // pending flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      pend <= (pend & ~clr_c) | evt_c;
      ovf  <= ovf_set_c | (ovf & ~ovf_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= 2'd0;
      last      <= 2'd3;
    end else begin
      state     <= state_n;
      cmd_valid <= cmd_valid_n;
      cmd_id    <= cmd_id_n;
      last      <= last_n;
    end
  end

  // round-robin pick from last+1 upward; descending loop leaves the nearest set bit
  always_comb begin
    state_n     = state;
    cmd_valid_n = cmd_valid;
    cmd_id_n    = cmd_id;
    last_n      = last;
    sel_c       = last;
    idx_c       = last;
    for (int k = NB - 1; k >= 0; k--) begin
      idx_c = last + 2'(k) + 2'd1;
      if (pend[idx_c]) sel_c = idx_c;
    end
    case (state)
      IDLE: begin
        cmd_valid_n = 1'b0;
        if (|pend) begin
          cmd_id_n    = sel_c;
          cmd_valid_n = 1'b1;
          state_n     = PRESENT;
        end
      end
      PRESENT: begin
        if (cmd_ready) begin
          last_n      = cmd_id;
          cmd_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        cmd_valid_n = 1'b0;
        state_n     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed vector bench for btn_cmd_arbiter with DIV_W=2, DB_CNT=3, RPT_TICKS=4.
module tb_btn_cmd_arbiter;

  localparam int OP_NONE  = 0;
  localparam int OP_LAT   = 1;
  localparam int OP_BNC   = 2;
  localparam int OP_RST   = 3;
  localparam int NV       = 21;

  typedef struct {
    int         op;
    logic [3:0] btn;
    logic       rdy;
    logic       clr;
    int         ncyc;
    logic       valid;
    logic [1:0] id;
    logic [3:0] pend;
    logic       ovf;
    int         ncmd;
    logic [7:0] ids;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       cmd_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] pend;
  logic       ovf;

  int         n_chk = 0;
  int         n_fail = 0;

  logic [1:0] hs_id  [0:255];
  int         hs_cyc [0:255];
  int         hs_n = 0;
  int         cyc = 0;

  vec_t       vt [0:NV-1];

  btn_cmd_arbiter #(.DIV_W(2), .DB_CNT(3), .RPT_TICKS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_u     (btn[0]),
    .btn_lw    (btn[1]),
    .btn_lft   (btn[2]),
    .btn_ri    (btn[3]),
    .cmd_ready (cmd_ready),
    .ovf_clr   (ovf_clr),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pend      (pend),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // log every accepted command (valid and ready ahead of the next rising edge)
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && hs_n < 256) begin
      hs_id[hs_n]  <= cmd_id;
      hs_cyc[hs_n] <= cyc;
      hs_n         <= hs_n + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [3:0] b, input logic r, input logic c,
                              input int n, input logic v, input logic [1:0] id,
                              input logic [3:0] p, input logic o, input int nc,
                              input logic [7:0] ids);
    vec_t x;
    x.op = op; x.btn = b; x.rdy = r; x.clr = c; x.ncyc = n; x.valid = v; x.id = id;
    x.pend = p; x.ovf = o; x.ncmd = nc; x.ids = ids;
    return x;
  endfunction

  initial begin
    int start;
    int lat;
    int nact;
    logic [7:0] idsv;

    vt[0]  = mk(OP_NONE, 4'b0000, 1'b1, 1'b0,  8, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[1]  = mk(OP_LAT,  4'b0001, 1'b1, 1'b0, 40, 1'b0, 2'd0, 4'h0, 1'b0, 1, 8'h00);
    vt[2]  = mk(OP_NONE, 4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[3]  = mk(OP_BNC,  4'b1000, 1'b1, 1'b0, 40, 1'b0, 2'd0, 4'h0, 1'b0, 1, 8'h03);
    vt[4]  = mk(OP_NONE, 4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[5]  = mk(OP_NONE, 4'b1111, 1'b1, 1'b0, 40, 1'b0, 2'd0, 4'h0, 1'b0, 4, 8'hE4);
    vt[6]  = mk(OP_NONE, 4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[7]  = mk(OP_NONE, 4'b0011, 1'b1, 1'b0, 40, 1'b0, 2'd0, 4'h0, 1'b0, 2, 8'h04);
    vt[8]  = mk(OP_NONE, 4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[9]  = mk(OP_NONE, 4'b0010, 1'b0, 1'b0, 30, 1'b1, 2'd1, 4'h2, 1'b0, 0, 8'h00);
    vt[10] = mk(OP_NONE, 4'b0000, 1'b0, 1'b0, 30, 1'b1, 2'd1, 4'h2, 1'b0, 0, 8'h00);
    vt[11] = mk(OP_NONE, 4'b0010, 1'b0, 1'b0, 30, 1'b1, 2'd1, 4'h2, 1'b1, 0, 8'h00);
    vt[12] = mk(OP_NONE, 4'b0010, 1'b0, 1'b1,  1, 1'b1, 2'd1, 4'h2, 1'b0, 0, 8'h00);
    vt[13] = mk(OP_NONE, 4'b0010, 1'b1, 1'b0,  4, 1'b0, 2'd0, 4'h0, 1'b0, 1, 8'h01);
    vt[14] = mk(OP_NONE, 4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[15] = mk(OP_NONE, 4'b0001, 1'b0, 1'b0, 30, 1'b1, 2'd0, 4'h1, 1'b0, 0, 8'h00);
    vt[16] = mk(OP_NONE, 4'b0000, 1'b0, 1'b0, 30, 1'b1, 2'd0, 4'h1, 1'b0, 0, 8'h00);
    vt[17] = mk(OP_NONE, 4'b0001, 1'b0, 1'b0, 30, 1'b1, 2'd0, 4'h1, 1'b1, 0, 8'h00);
    vt[18] = mk(OP_RST,  4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);
    vt[19] = mk(OP_NONE, 4'b0001, 1'b1, 1'b0, 40, 1'b0, 2'd0, 4'h0, 1'b0, 1, 8'h00);
    vt[20] = mk(OP_NONE, 4'b0000, 1'b1, 1'b0, 30, 1'b0, 2'd0, 4'h0, 1'b0, 0, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", int'(cmd_valid), 0);
    chk("reset.id",    int'(cmd_id),    0);
    chk("reset.pend",  int'(pend),      0);
    chk("reset.ovf",   int'(ovf),       0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vt[i].op == OP_BNC) begin
        start     = hs_n;
        cmd_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
          btn = {((t / 3) % 2 == 0), 3'b000};
          @(posedge clk);
          #1;
        end
        chk($sformatf("v%0d.bounce_cmds", i), hs_n - start, 0);
      end
      if (vt[i].op == OP_RST) begin
        btn   = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk($sformatf("v%0d.rst_valid", i), int'(cmd_valid), 0);
        chk($sformatf("v%0d.rst_pend", i),  int'(pend),      0);
        chk($sformatf("v%0d.rst_ovf", i),   int'(ovf),       0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end

      start     = hs_n;
      lat       = -1;
      btn       = vt[i].btn;
      cmd_ready = vt[i].rdy;
      ovf_clr   = vt[i].clr;
      for (int c = 1; c <= vt[i].ncyc; c++) begin
        @(posedge clk);
        #1;
        if (lat < 0 && cmd_valid) lat = c;
      end
      ovf_clr = 1'b0;

      if (vt[i].op == OP_LAT) begin
        chk($sformatf("v%0d.latency_ok", i), int'(lat >= 13 && lat <= 16), 1);
      end
      chk($sformatf("v%0d.valid", i), int'(cmd_valid), int'(vt[i].valid));
      if (vt[i].valid) chk($sformatf("v%0d.id", i), int'(cmd_id), int'(vt[i].id));
      chk($sformatf("v%0d.pend", i), int'(pend), int'(vt[i].pend));
      chk($sformatf("v%0d.ovf", i),  int'(ovf),  int'(vt[i].ovf));
      nact = hs_n - start;
      chk($sformatf("v%0d.ncmd", i), nact, vt[i].ncmd);
      idsv = vt[i].ids;
      for (int k = 0; k < 4; k++) begin
        if (k < vt[i].ncmd && k < nact)
          chk($sformatf("v%0d.cmd%0d_id", i, k), int'(hs_id[start + k]), int'(idsv[2*k +: 2]));
      end
    end

    // held btn_lft: single event, or a steady 16-clk repeat when auto-repeat is built in
    start     = hs_n;
    cmd_ready = 1'b1;
    btn       = 4'b0100;
    repeat (80) @(posedge clk);
    #1;
    btn = 4'b0000;
    repeat (30) @(posedge clk);
    #1;
    nact = hs_n - start;
`ifdef BTN_AUTO_REPEAT_EN
    chk("rpt.enough_cmds", int'(nact >= 4), 1);
    for (int k = 1; k < nact; k++)
      chk($sformatf("rpt.interval%0d", k), hs_cyc[start + k] - hs_cyc[start + k - 1], 16);
`else
    chk("rpt.single_cmd", nact, 1);
`endif
    for (int k = 0; k < nact && k < 8; k++)
      chk($sformatf("rpt.cmd%0d_id", k), int'(hs_id[start + k]), 2);
    chk("rpt.pend", int'(pend), 0);
    chk("rpt.valid", int'(cmd_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
